// File: rtl/bids22_round_logger.sv
// ============================================================================
// Module   : bids22_round_logger
// Purpose  : Logs bids22 auction round results into a show-ahead FIFO and
//            keeps saturating per-bidder win counts and total revenue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bids22_round_logger #(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    roundOver,
  input  logic                    X_win,
  input  logic                    Y_win,
  input  logic                    Z_win,
  input  logic [31:0]             maxBid,
  input  logic                    rd_en,
  input  logic                    clr_ovf,
  output logic                    rd_valid,
  output logic [1:0]              rd_winner,
  output logic [31:0]             rd_price,
  output logic [7:0]              rd_round,
  output logic                    rd_multi,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [7:0]              X_wins,
  output logic [7:0]              Y_wins,
  output logic [7:0]              Z_wins,
  output logic [31:0]             revenue
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 43;
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic          r_round_over_d;
  logic [7:0]    r_round;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [7:0]    r_x_wins;
  logic [7:0]    r_y_wins;
  logic [7:0]    r_z_wins;
  logic [31:0]   r_revenue;
  logic [RW-1:0] r_mem [DEPTH];

  logic          w_event;
  logic [1:0]    w_win_cnt;
  logic          w_single;
  logic          w_multi;
  logic [1:0]    w_winner;
  logic [31:0]   w_price;
  logic [RW-1:0] w_rec;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [32:0]   w_rev_sum;
  logic [RW-1:0] w_head;

  assign w_event   = roundOver & ~r_round_over_d;
  assign w_win_cnt = {1'b0, X_win} + {1'b0, Y_win} + {1'b0, Z_win};

  always_comb begin
    w_single = 1'b0;
    w_multi  = 1'b0;
    w_winner = 2'b00;
    w_price  = 32'd0;
    case (w_win_cnt)
      2'd0: ;
      2'd1: begin
        w_single = 1'b1;
        w_price  = maxBid;
        if (X_win)      w_winner = 2'b01;
        else if (Y_win) w_winner = 2'b10;
        else            w_winner = 2'b11;
      end
      default: begin
        w_multi = 1'b1;
        w_price = maxBid;
      end
    endcase
  end

  assign w_rec  = {w_winner, w_price, r_round, w_multi};
  assign w_full = (r_count == C_FULL);
  // A pop against an empty FIFO is ignored, so it can never free a slot.
  assign w_pop  = rd_en & (r_count != '0);
  assign w_push = w_event & (~w_full | w_pop);
  assign w_drop = w_event & w_full & ~w_pop;

  assign w_rev_sum = {1'b0, r_revenue} + {1'b0, maxBid};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_round_over_d <= 1'b0;
      r_round        <= 8'd0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_overflow     <= 1'b0;
      r_x_wins       <= 8'd0;
      r_y_wins       <= 8'd0;
      r_z_wins       <= 8'd0;
      r_revenue      <= 32'd0;
    end else begin
      r_round_over_d <= roundOver;

      if (w_event) r_round <= r_round + 8'd1;
      if (w_push)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase

      if (w_drop)       r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;

      // Statistics follow every single-winner event, stored or dropped.
      if (w_event && w_single) begin
        if (X_win && r_x_wins != 8'hFF) r_x_wins <= r_x_wins + 8'd1;
        if (Y_win && r_y_wins != 8'hFF) r_y_wins <= r_y_wins + 8'd1;
        if (Z_win && r_z_wins != 8'hFF) r_z_wins <= r_z_wins + 8'd1;
        r_revenue <= w_rev_sum[32] ? 32'hFFFF_FFFF : w_rev_sum[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rec;
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign rd_valid  = (r_count != '0);
  assign rd_winner = w_head[42:41];
  assign rd_price  = w_head[40:9];
  assign rd_round  = w_head[8:1];
  assign rd_multi  = w_head[0];
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign X_wins    = r_x_wins;
  assign Y_wins    = r_y_wins;
  assign Z_wins    = r_z_wins;
  assign revenue   = r_revenue;

endmodule

`default_nettype wire

// File: tb/tb_bids22_round_logger.sv
// ============================================================================
// Module   : tb_bids22_round_logger
// Purpose  : Scoreboard bench for bids22_round_logger (DEPTH = 8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bids22_round_logger;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset_n;
  logic        roundOver;
  logic        X_win;
  logic        Y_win;
  logic        Z_win;
  logic [31:0] maxBid;
  logic        rd_en;
  logic        clr_ovf;
  logic        rd_valid;
  logic [1:0]  rd_winner;
  logic [31:0] rd_price;
  logic [7:0]  rd_round;
  logic        rd_multi;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  X_wins;
  logic [7:0]  Y_wins;
  logic [7:0]  Z_wins;
  logic [31:0] revenue;

  bids22_round_logger #(.DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .roundOver (roundOver),
    .X_win     (X_win),
    .Y_win     (Y_win),
    .Z_win     (Z_win),
    .maxBid    (maxBid),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .rd_valid  (rd_valid),
    .rd_winner (rd_winner),
    .rd_price  (rd_price),
    .rd_round  (rd_round),
    .rd_multi  (rd_multi),
    .count     (count),
    .overflow  (overflow),
    .X_wins    (X_wins),
    .Y_wins    (Y_wins),
    .Z_wins    (Z_wins),
    .revenue   (revenue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state; records are {winner, price, round, multi}.
  logic [42:0] m_q [$];
  logic        m_prev_ro;
  logic [7:0]  m_round;
  logic        m_ovf;
  int          m_xw, m_yw, m_zw;
  longint      m_rev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev_ro = 1'b0;
    m_round   = 8'd0;
    m_ovf     = 1'b0;
    m_xw = 0; m_yw = 0; m_zw = 0;
    m_rev = 0;
  endtask

  task automatic check_all();
    check("rd_valid", 64'(rd_valid), 64'(m_q.size() != 0));
    check("count",    64'(count),    64'(m_q.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("X_wins",   64'(X_wins),   64'(m_xw));
    check("Y_wins",   64'(Y_wins),   64'(m_yw));
    check("Z_wins",   64'(Z_wins),   64'(m_zw));
    check("revenue",  64'(revenue),  64'(m_rev));
    if (m_q.size() != 0)
      check("head_record", 64'({rd_winner, rd_price, rd_round, rd_multi}), 64'(m_q[0]));
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic ro, input logic x, input logic y, input logic z,
                      input logic [31:0] bid, input logic rd, input logic clr);
    logic        ev, pop, full;
    int          nw;
    logic [1:0]  win;
    logic [31:0] price;
    logic        multi;
    roundOver = ro; X_win = x; Y_win = y; Z_win = z;
    maxBid = bid; rd_en = rd; clr_ovf = clr;

    ev   = ro && !m_prev_ro;
    full = (m_q.size() == DEPTH);
    pop  = rd && (m_q.size() != 0);
    nw   = int'(x) + int'(y) + int'(z);
    win  = 2'b00; price = 32'd0; multi = 1'b0;
    if (nw == 1) begin
      win = x ? 2'b01 : (y ? 2'b10 : 2'b11);
      price = bid;
    end else if (nw > 1) begin
      multi = 1'b1;
      price = bid;
    end
    if (pop) void'(m_q.pop_front());
    if (ev) begin
      if (!full || pop) m_q.push_back({win, price, m_round, multi});
      m_round = m_round + 8'd1;
      if (nw == 1) begin
        if (x && m_xw < 255) m_xw++;
        if (y && m_yw < 255) m_yw++;
        if (z && m_zw < 255) m_zw++;
        m_rev = m_rev + longint'(bid);
        if (m_rev > 64'hFFFF_FFFF) m_rev = 64'hFFFF_FFFF;
      end
    end
    if (ev && full && !pop) m_ovf = 1'b1;
    else if (clr)           m_ovf = 1'b0;
    m_prev_ro = ro;

    @(posedge clk);
    #1;
    check_all();
  endtask

  // One full event pulse: roundOver high for a cycle, then low.
  task automatic round(input logic x, input logic y, input logic z,
                       input logic [31:0] bid, input logic rd);
    step(1'b1, x, y, z, bid, rd, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_count",    64'(count),    64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_wins",     64'({X_wins, Y_wins, Z_wins}), 64'd0);
    check("rst_revenue",  64'(revenue),  64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; roundOver = 1'b0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0;
    maxBid = 32'd0; rd_en = 1'b0; clr_ovf = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single round: Y wins at 0x64.
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h64, 1'b0, 1'b0);
    check("single_winner", 64'(rd_winner), 64'd2);
    check("single_price",  64'(rd_price),  64'h64);
    check("single_round",  64'(rd_round),  64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h64, 1'b0, 1'b0);   // held high: no new event
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Fill and overflow from a fresh reset.
    #2;
    do_reset();
    for (int i = 0; i < 9; i++)
      round(i % 3 == 0, i % 3 == 1, i % 3 == 2, 32'(i + 1), 1'b0);
    check("fill_count", 64'(count),    64'd8);
    check("fill_ovf",   64'(overflow), 64'd1);
    check("fill_head",  64'(rd_round), 64'd0);

    // Full with simultaneous pop and event, then drop with clr_ovf (set wins).
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h55, 1'b1, 1'b0);
    check("full_pop_count", 64'(count), 64'd8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 1'b0, 1'b1);
    check("drop_clr_ovf", 64'(overflow), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check("clr_ovf", 64'(overflow), 64'd0);

    // Drain, then pop on empty and event-on-empty with rd_en.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("drained", 64'(rd_valid), 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h9, 1'b1, 1'b0);
    check("empty_event_count", 64'(count), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Multi-win and no-win rounds.
    round(1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
    check("multi_flag",   64'(rd_multi),  64'd1);
    check("multi_winner", 64'(rd_winner), 64'd0);
    check("multi_price",  64'(rd_price),  64'h10);
    round(1'b0, 1'b0, 1'b0, 32'h33, 1'b0);
    round(1'b1, 1'b1, 1'b1, 32'h44, 1'b0);

    // Saturation of revenue and X win counter.
    #2;
    do_reset();
    round(1'b0, 1'b1, 1'b0, 32'h7FFF_FFF8, 1'b1);
    round(1'b0, 1'b1, 1'b0, 32'h7FFF_FFF8, 1'b1);
    check("rev_preload", 64'(revenue), 64'hFFFF_FFF0);
    round(1'b1, 1'b0, 1'b0, 32'h20, 1'b1);
    check("rev_sat", 64'(revenue), 64'hFFFF_FFFF);
    for (int i = 0; i < 256; i++)
      round(1'b1, 1'b0, 1'b0, 32'(i), (i % 4) == 0);
    check("xwins_sat", 64'(X_wins), 64'd255);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0));

    // Reset mid-run with 3 records; roundOver held high through release.
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) round(1'b0, 1'b0, 1'b1, 32'(i + 5), 1'b0);
    check("pre_reset_count", 64'(count), 64'd3);
    #2;
    reset_n = 1'b0;
    roundOver = 1'b1;
    #1;
    model_reset();
    check("mid_rst_count", 64'(count),    64'd0);
    check("mid_rst_valid", 64'(rd_valid), 64'd0);
    check("mid_rst_zwins", 64'(Z_wins),   64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h21, 1'b0, 1'b0);
    check("post_rst_count", 64'(count),    64'd1);
    check("post_rst_round", 64'(rd_round), 64'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h21, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
